// File: rtl/fpnew_result_buffer.sv
// Result FIFO between the FPNew wrapper output handshake and the writeback consumer.
// Keeps results in order and accrues sticky IEEE flags of retired entries.
module fpnew_result_buffer #(
    parameter int unsigned FLEN      = 64,
    parameter int unsigned TAG_WIDTH = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [FLEN-1:0]          fpu_result_i,
    input  logic [4:0]               fpu_status_i,
    input  logic [TAG_WIDTH-1:0]     fpu_tag_i,
    input  logic                     fpu_valid_i,
    output logic                     fpu_ready_o,
    output logic [FLEN-1:0]          resp_result_o,
    output logic [4:0]               resp_status_o,
    output logic [TAG_WIDTH-1:0]     resp_tag_o,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [4:0]               fflags_o,
    input  logic                     fflags_clr_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FLEN-1:0]      result_mem [DEPTH];
    logic [4:0]           status_mem [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             push, pop;

    // Ready comes only from the occupancy register, so resp_ready_i never reaches the FPU.
    assign fpu_ready_o  = (count_q != FULL_CNT);
    assign resp_valid_o = (count_q != '0);
    assign push         = fpu_valid_i & fpu_ready_o & ~flush_i;
    assign pop          = resp_valid_o & resp_ready_i & ~flush_i;

    assign resp_result_o = resp_valid_o ? result_mem[rd_ptr_q] : '0;
    assign resp_status_o = resp_valid_o ? status_mem[rd_ptr_q] : '0;
    assign resp_tag_o    = resp_valid_o ? tag_mem[rd_ptr_q]    : '0;
    assign fflags_o      = fflags_q;
    assign count_o       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | (pop ? resp_status_o : 5'd0);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    // NOTE: storage is deliberately not reset; head outputs are masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            result_mem[wr_ptr_q] <= fpu_result_i;
            status_mem[wr_ptr_q] <= fpu_status_i;
            tag_mem[wr_ptr_q]    <= fpu_tag_i;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == FULL_CNT));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && count_q == '0));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Self-checking bench for fpnew_result_buffer: directed vector table, random stream
// against a reference queue, and hand-written async reset sequence.
module tb_fpnew_result_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [63:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic [1:0]  fpu_tag_i;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [63:0] resp_result_o;
    logic [4:0]  resp_status_o;
    logic [1:0]  resp_tag_o;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic [2:0]  count_o;

    fpnew_result_buffer #(.FLEN(64), .TAG_WIDTH(2), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fpu_result_i (fpu_result_i),
        .fpu_status_i (fpu_status_i),
        .fpu_tag_i    (fpu_tag_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .resp_result_o(resp_result_o),
        .resp_status_o(resp_status_o),
        .resp_tag_o   (resp_tag_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  sts;
        logic [1:0]  tag;
    } entry_t;

    typedef struct {
        logic        v;
        logic [63:0] res;
        logic [4:0]  sts;
        logic [1:0]  tag;
        logic        rdy;
        logic        fl;
        logic        clr;
        int          exp_cnt;
        logic [4:0]  exp_ff;
    } vec_t;

    entry_t     sb[$];
    logic [4:0] m_fflags;
    logic       last_push;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference queue model.
    task automatic check_state();
        check("count", 64'(count_o), 64'(sb.size()));
        check("fpu_ready", 64'(fpu_ready_o), 64'(sb.size() != DEPTH));
        check("resp_valid", 64'(resp_valid_o), 64'(sb.size() != 0));
        check("fflags", 64'(fflags_o), 64'(m_fflags));
        if (sb.size() != 0) begin
            check("resp_result", resp_result_o, sb[0].res);
            check("resp_status", 64'(resp_status_o), 64'(sb[0].sts));
            check("resp_tag", 64'(resp_tag_o), 64'(sb[0].tag));
        end else begin
            check("resp_result_empty", resp_result_o, 64'd0);
            check("resp_tag_empty", 64'(resp_tag_o), 64'd0);
        end
    endtask

    // One clock cycle: check, drive, predict, advance to the next falling edge.
    task automatic step(input logic v, input logic [63:0] r, input logic [4:0] s,
                        input logic [1:0] t, input logic rdy, input logic fl, input logic clr);
        logic       m_push, m_pop;
        logic [4:0] ff_n;
        entry_t     e;
        check_state();
        fpu_valid_i  = v;
        fpu_result_i = r;
        fpu_status_i = s;
        fpu_tag_i    = t;
        resp_ready_i = rdy;
        flush_i      = fl;
        fflags_clr_i = clr;
        m_push = v && (sb.size() != DEPTH) && !fl;
        m_pop  = (sb.size() != 0) && rdy && !fl;
        ff_n   = clr ? 5'd0 : m_fflags;
        if (m_pop) ff_n = ff_n | sb[0].sts;
        e.res = r;
        e.sts = s;
        e.tag = t;
        @(posedge clk_i);
        m_fflags = ff_n;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop)  void'(sb.pop_front());
            if (m_push) sb.push_back(e);
        end
        last_push = m_push;
        @(negedge clk_i);
    endtask

    vec_t vecs[25];

    initial begin
        int pushed;
        int budget;
        logic rv, rr;

        //            v  result                 sts    tag rdy fl clr  cnt ff
        vecs[0]  = '{1'b1, 64'h3F800000,        5'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1, 5'h00};
        vecs[1]  = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 0, 5'h00};
        vecs[2]  = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 0, 5'h00};
        vecs[3]  = '{1'b1, 64'h10,              5'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1, 5'h00};
        vecs[4]  = '{1'b1, 64'h11,              5'h00, 2'd1, 1'b0, 1'b0, 1'b0, 2, 5'h00};
        vecs[5]  = '{1'b1, 64'h12,              5'h00, 2'd2, 1'b0, 1'b0, 1'b0, 3, 5'h00};
        vecs[6]  = '{1'b1, 64'h13,              5'h00, 2'd3, 1'b0, 1'b0, 1'b0, 4, 5'h00};
        vecs[7]  = '{1'b1, 64'h14,              5'h00, 2'd0, 1'b0, 1'b0, 1'b0, 4, 5'h00};
        vecs[8]  = '{1'b1, 64'h14,              5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 3, 5'h00};
        vecs[9]  = '{1'b1, 64'h14,              5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 3, 5'h00};
        vecs[10] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 2, 5'h00};
        vecs[11] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1, 5'h00};
        vecs[12] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 0, 5'h00};
        vecs[13] = '{1'b1, 64'hA,               5'h01, 2'd0, 1'b0, 1'b0, 1'b0, 1, 5'h00};
        vecs[14] = '{1'b1, 64'hB,               5'h10, 2'd1, 1'b0, 1'b0, 1'b0, 2, 5'h00};
        vecs[15] = '{1'b1, 64'hC,               5'h04, 2'd2, 1'b0, 1'b0, 1'b0, 3, 5'h00};
        vecs[16] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 2, 5'h01};
        vecs[17] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1, 5'h11};
        vecs[18] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1, 5'h11};
        vecs[19] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b1, 0, 5'h04};
        vecs[20] = '{1'b1, 64'hD,               5'h02, 2'd3, 1'b0, 1'b0, 1'b0, 1, 5'h04};
        vecs[21] = '{1'b1, 64'hE,               5'h08, 2'd0, 1'b0, 1'b0, 1'b0, 2, 5'h04};
        vecs[22] = '{1'b1, 64'hF,               5'h01, 2'd1, 1'b0, 1'b0, 1'b0, 3, 5'h04};
        vecs[23] = '{1'b1, 64'hBAD,             5'h1F, 2'd2, 1'b1, 1'b1, 1'b0, 0, 5'h04};
        vecs[24] = '{1'b0, 64'h0,               5'h00, 2'd0, 1'b1, 1'b0, 1'b0, 0, 5'h04};

        rst_ni = 1'b0; flush_i = 1'b0; fpu_valid_i = 1'b0; fpu_result_i = '0;
        fpu_status_i = '0; fpu_tag_i = '0; resp_ready_i = 1'b0; fflags_clr_i = 1'b0;
        m_fflags = '0; last_push = 1'b0;

        #12;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(resp_valid_o), 64'd0);
        check("rst_ready", 64'(fpu_ready_o), 64'd1);
        check("rst_fflags", 64'(fflags_o), 64'd0);
        check("rst_result", resp_result_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed vectors: single push, fill/full/drain, fflags accrual, flush.
        for (int i = 0; i < 25; i++) begin
            step(vecs[i].v, vecs[i].res, vecs[i].sts, vecs[i].tag,
                 vecs[i].rdy, vecs[i].fl, vecs[i].clr);
            check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_fflags", i), 64'(fflags_o), 64'(vecs[i].exp_ff));
        end

        // Random stream of 1000 results with 50% consumer back-pressure.
        pushed = 0;
        budget = 0;
        while (pushed < 1000 && budget < 20000) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            resp_ready_i = ~rr;
            #1;
            check("ready_indep", 64'(fpu_ready_o), 64'(sb.size() != DEPTH));
            resp_ready_i = rr;
            #1;
            step(rv, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 2'(pushed),
                 rr, 1'b0, ($urandom_range(0, 15) == 0));
            if (last_push) pushed++;
            budget++;
        end
        check("stream_pushed", 64'(pushed), 64'd1000);
        for (int i = 0; i < 8 && sb.size() != 0; i++)
            step(1'b0, 64'h0, 5'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("stream_drained", 64'(count_o), 64'd0);

        // Async reset mid-stream with two entries buffered and nonzero flags.
        step(1'b1, 64'h55, 5'h08, 2'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h66, 5'h00, 2'd3, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count_o), 64'd2);
        step(1'b0, 64'h0, 5'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_fflags_set", 64'(fflags_o != 5'd0), 64'd1);
        step(1'b1, 64'h77, 5'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count2", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(resp_valid_o), 64'd0);
        check("arst_ready", 64'(fpu_ready_o), 64'd1);
        check("arst_fflags", 64'(fflags_o), 64'd0);
        check("arst_result", resp_result_o, 64'd0);
        check("arst_tag", 64'(resp_tag_o), 64'd0);
        sb.delete();
        m_fflags = '0;
        fpu_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 64'h3F800000, 5'h00, 2'd1, 1'b1, 1'b0, 1'b0);
        check("post_rst_count1", 64'(count_o), 64'd1);
        check("post_rst_result", resp_result_o, 64'h3F800000);
        step(1'b0, 64'h0, 5'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        check("post_rst_count0", 64'(count_o), 64'd0);
        check_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
